lsu_mem_ctrl: RTL and testbench

Load/store unit between the execute stage and the word-wide data memory. It accepts one memory request at a time over a valid/ready handshake and decodes the RV32 load/store width. It performs read-modify-write for byte and halfword stores, because the memory only writes whole words. Loaded data is sign- or zero-extended, and misaligned, out-of-range or illegal accesses return an error response without touching memory.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_byte_lane.sv | 68 ++++++
 rtl/lsu_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32 funct3 width codes for loads and stores
//   - lsu_state_e: controller state encoding
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational byte-lane steering for the load/store unit.
// Ports:
//   word_i     - word read from data memory
//   wdata_i    - right-aligned store data
//   addr_lo_i  - byte offset inside the word
//   funct3_i   - RV32 width code
//   ld_data_o  - extracted and sign/zero-extended load result
//   st_word_o  - word_i with the store data merged into its lane
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [2:0]  f3);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    // Halfword offsets are always 0 or 2 here, so one byte shift covers both.
    shifted = word >> {lo, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      LSU_B:   res = 32'(byte_s);
      LSU_H:   res = 32'(half_s);
      LSU_W:   res = word;
      LSU_BU:  res = {24'h0, shifted[7:0]};
      LSU_HU:  res = {16'h0, shifted[15:0]};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lo,
                                              input logic [2:0]  f3);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3)
      LSU_B: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        data = {24'h0, wdata[7:0]} << {lo, 3'b000};
      end
      LSU_H: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        data = {16'h0, wdata[15:0]} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (old_word & ~mask) | (data & mask);
  endfunction

  assign ld_data_o = load_extend(word_i, addr_lo_i, funct3_i);
  assign st_word_o = store_merge(word_i, wdata_i, addr_lo_i, funct3_i);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between execute and a word-wide data memory.
// One request at a time; byte/halfword stores are done as read-modify-write
// because the memory only writes whole words. Illegal, misaligned or
// out-of-range accesses respond with rsp_err_o and never touch memory.
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      - request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i         - store flag and RV32 width code
//   req_addr_i, req_wdata_i        - byte address, right-aligned store data
//   rsp_valid_o / rsp_ready_i      - response handshake
//   rsp_data_o, rsp_err_o          - extended load data, access fault
//   dmem_st_en_o, dmem_addr_o      - memory word write enable, byte address
//   dmem_st_data_o                 - full word to write
//   dmem_ld_data_i                 - combinational memory read data
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DMEM_AW = 11
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_data_o,
  output logic               rsp_err_o,
  output logic               dmem_st_en_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [31:0]        dmem_st_data_o,
  input  logic [31:0]        dmem_ld_data_i
);

  lsu_state_e         state_q;
  lsu_state_e         state_d;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [DMEM_AW-1:0] addr_q;
  logic [31:0]        word_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;

  logic               f3_ok;
  logic               align_ok;
  logic               range_ok;
  logic               req_err;
  logic [31:0]        lane_ld_data;
  logic [31:0]        lane_st_word;

  // Request legality, evaluated on the raw request in the accept cycle
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    if (req_we_i) begin
      f3_ok = req_funct3_i inside {LSU_B, LSU_H, LSU_W};
    end else begin
      f3_ok = req_funct3_i inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
    end
    // funct3[1:0] encodes the access size for every legal code
    case (req_funct3_i[1:0])
      2'b01:   align_ok = ~req_addr_i[0];
      2'b10:   align_ok = (req_addr_i[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = (req_addr_i[31:DMEM_AW] == '0);
    req_err  = ~(f3_ok & align_ok & range_ok);
  end

  // The write path reuses word_q: it holds the store data until the
  // read-modify-write cycle replaces it with the merged word.
  lsu_byte_lane u_byte_lane (
    .word_i    (dmem_ld_data_i),
    .wdata_i   (word_q),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .ld_data_o (lane_ld_data),
    .st_word_o (lane_st_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err) begin
            state_d = RESP;
          end else if (!req_we_i) begin
            state_d = LOAD;
          end else if (req_funct3_i == LSU_W) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept / load / merge register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      word_q     <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q       <= req_we_i;
            funct3_q   <= req_funct3_i;
            addr_q     <= req_addr_i[DMEM_AW-1:0];
            rsp_data_q <= 32'h0;
            rsp_err_q  <= req_err;
            if (req_we_i) begin
              word_q <= req_wdata_i;
            end
          end
        end
        LOAD:    rsp_data_q <= we_q ? 32'h0 : lane_ld_data;
        RMW_RD:  word_q     <= lane_st_word;
        default: ;
      endcase
    end
  end

  // Decoded straight from state so an asynchronous reset cancels a write at once
  assign req_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign dmem_st_en_o   = (state_q == WRITE);
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_st_data_o = word_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  localparam int AW = 11;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [2:0]    req_funct3_i = 3'b000;
  logic [31:0]   req_addr_i = 32'h0;
  logic [31:0]   req_wdata_i = 32'h0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_data_o;
  logic          rsp_err_o;
  logic          dmem_st_en_o;
  logic [AW-1:0] dmem_addr_o;
  logic [31:0]   dmem_st_data_o;
  logic [31:0]   dmem_ld_data_i;

  logic [31:0] env_mem [512];
  logic [31:0] mdl_mem [512];

  int n_chk  = 0;
  int n_pass = 0;

  lsu_mem_ctrl #(.DMEM_AW(AW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o),
    .dmem_st_en_o   (dmem_st_en_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_st_data_o (dmem_st_data_o),
    .dmem_ld_data_i (dmem_ld_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory: combinational read (0 while writing), word write on the edge
  assign dmem_ld_data_i = dmem_st_en_o ? 32'h0 : env_mem[dmem_addr_o[AW-1:2]];
  always @(posedge clk_i) begin
    if (dmem_st_en_o) env_mem[dmem_addr_o[AW-1:2]] <= dmem_st_data_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference behaviour of one access: fault, response data, response
  // latency in cycles after accept, and the word that memory must receive.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output bit err, output logic [31:0] data,
                       output int lat, output bit st, output logic [31:0] word);
    int          sz;
    bit          sgn;
    int          sh;
    logic [31:0] old;
    logic [31:0] m;
    err = 0; data = 32'h0; st = 0; word = 32'h0; sz = 1; sgn = 0; lat = 1;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: begin sz = 4; sgn = 0; end
      3'd4: begin sz = 1; sgn = 0; err = we; end
      3'd5: begin sz = 2; sgn = 0; err = we; end
      default: err = 1;
    endcase
    if ((addr % sz) != 0) err = 1;
    if (addr >= 32'd2048) err = 1;
    if (err) return;
    old = mdl_mem[addr[10:2]];
    sh  = 8 * int'(addr % 4);
    m   = (32'd1 << (8 * sz)) - 32'd1;
    if (!we) begin
      lat  = 2;
      data = (old >> sh) & m;
      if (sgn && sz < 4 && data[8*sz-1]) data = data | ~m;
    end else begin
      lat  = (sz == 4) ? 2 : 3;
      st   = 1;
      word = (old & ~(m << sh)) | ((wd & m) << sh);
      mdl_mem[addr[10:2]] = word;
    end
  endtask

  // Issue one request and check every cycle until the response handshake.
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall, input bit hold,
                         output logic [31:0] got_data, output logic got_err);
    bit          e_err, e_st, done;
    logic [31:0] e_data, e_word;
    int          e_lat, cyc;
    model(we, f3, addr, wd, e_err, e_data, e_lat, e_st, e_word);
    got_data = 32'hDEAD_BEEF;
    got_err  = 1'bx;
    @(negedge clk_i);
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd; rsp_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    if (hold) begin
      req_we_i = 1'($urandom); req_funct3_i = 3'($urandom);
      req_addr_i = $urandom; req_wdata_i = $urandom;
    end else begin
      req_valid_i = 1'b0;
    end
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      chk("req_ready_busy", 32'(req_ready_o), 32'd0);
      chk("dmem_addr", 32'(dmem_addr_o), 32'(addr[AW-1:0]));
      chk("st_en", 32'(dmem_st_en_o), 32'(e_st && cyc == e_lat - 1));
      if (dmem_st_en_o) chk("st_data", dmem_st_data_o, e_word);
      chk("rsp_valid", 32'(rsp_valid_o), 32'(cyc >= e_lat));
      if (rsp_valid_o) begin
        chk("rsp_data", rsp_data_o, e_data);
        chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
        got_data = rsp_data_o;
        got_err  = rsp_err_o;
        if (stall > 0) begin
          rsp_ready_i = 1'b0;
          stall--;
        end else begin
          rsp_ready_i = 1'b1;
          done = 1;
        end
      end
    end
    chk("rsp_timeout", 32'(done), 32'd1);
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data_o, 32'h0);
    chk({tag, "_st_en"}, 32'(dmem_st_en_o), 32'd0);
    chk({tag, "_addr"}, 32'(dmem_addr_o), 32'h0);
    chk({tag, "_st_data"}, dmem_st_data_o, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] v;
    int          legal [5] = '{0, 1, 2, 4, 5};
    bit          r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          sel;

    for (int i = 0; i < 512; i++) begin
      v = (i == 4) ? 32'h8899_AABB : $urandom;
      env_mem[i] <= v;
      mdl_mem[i] = v;
    end

    #1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: word load
    run_req(0, 3'd2, 32'h010, 32'h0, 0, 0, d, e);
    chk("lit_lw", d, 32'h8899_AABB);
    chk("lit_lw_err", 32'(e), 32'd0);

    // 2: sub-word loads
    run_req(0, 3'd0, 32'h013, 32'h0, 0, 0, d, e);
    chk("lit_lb", d, 32'hFFFF_FF88);
    run_req(0, 3'd4, 32'h013, 32'h0, 0, 0, d, e);
    chk("lit_lbu", d, 32'h0000_0088);
    run_req(0, 3'd1, 32'h012, 32'h0, 0, 0, d, e);
    chk("lit_lh", d, 32'hFFFF_8899);
    run_req(0, 3'd5, 32'h010, 32'h0, 0, 0, d, e);
    chk("lit_lhu", d, 32'h0000_AABB);

    // 3: byte store by read-modify-write, then read back
    run_req(1, 3'd0, 32'h011, 32'h1234_56CC, 0, 0, d, e);
    chk("lit_sb_data", d, 32'h0);
    chk("lit_sb_mdl", mdl_mem[4], 32'h8899_CCBB);
    chk("lit_sb_mem", env_mem[4], 32'h8899_CCBB);
    run_req(0, 3'd2, 32'h010, 32'h0, 0, 0, d, e);
    chk("lit_sb_readback", d, 32'h8899_CCBB);

    // 4: faults
    run_req(0, 3'd1, 32'h011, 32'h0, 0, 0, d, e);
    chk("lit_err_lh_mis", 32'(e), 32'd1);
    chk("lit_err_lh_data", d, 32'h0);
    run_req(1, 3'd2, 32'h0000_0800, 32'hCAFE_F00D, 0, 0, d, e);
    chk("lit_err_sw_range", 32'(e), 32'd1);
    run_req(0, 3'd3, 32'h010, 32'h0, 0, 0, d, e);
    chk("lit_err_f3", 32'(e), 32'd1);
    chk("lit_err_mem", env_mem[4], 32'h8899_CCBB);

    // 5: stalled response with a competing request held on the bus
    run_req(0, 3'd2, 32'h010, 32'h0, 5, 1, d, e);
    chk("lit_stall_lw", d, 32'h8899_CCBB);

    // restore the preload, then 6: reset during the write of a halfword store
    run_req(1, 3'd2, 32'h010, 32'h8899_AABB, 0, 0, d, e);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd1;
    req_addr_i = 32'h012; req_wdata_i = 32'h5555_1234;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_write_seen", 32'(dmem_st_en_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk_i);
    #1;
    chk("midrst_mem", env_mem[4], 32'h8899_AABB);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) r_f3 = 3'(legal[$urandom_range(0, 4)]);
      else r_f3 = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) r_addr = $urandom;
      else if (sel == 1) r_addr = 32'h800 + $urandom_range(0, 15);
      else r_addr = $urandom_range(0, 63);
      run_req(r_we, r_f3, r_addr, $urandom, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), d, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
